// File: rtl/ccd_pkg.sv
// Shared timing constants and helpers for the linear-CCD timing generator.
package ccd_pkg;

    // Default timing for a TCD1304-class sensor driven from a 50 MHz clock.
    localparam int unsigned CCD_MCLK_HALF = 12;     // sys clocks per Master half-period
    localparam int unsigned CCD_FRAME_LEN = 14776;  // Master cycles per readout frame
    localparam int unsigned CCD_ICG_LOW   = 5;      // Master cycles Icg held low
    localparam int unsigned CCD_SH_START  = 1;      // frame count of the transfer pulse
    localparam int unsigned CCD_SH_WIDTH  = 2;      // Sh pulse width in Master cycles
    localparam int unsigned CCD_SH_MIN    = 4;      // shortest allowed Sh period

    // Unsigned clamp of the requested Sh period to the minimum legal period.
    function automatic logic [15:0] clamp_period(input logic [15:0] req,
                                                 input logic [15:0] pmin);
        logic [15:0] res;
        if (req < pmin) begin
            res = pmin;
        end else begin
            res = req;
        end
        return res;
    endfunction

endpackage

// File: rtl/ccd_mclk_div.sv
// Master clock divider: divides the system clock by 2*MCLK_HALF and flags
// the system-clock edge on which Master rises (the "tick").
module ccd_mclk_div
    import ccd_pkg::*;
#(
    parameter int unsigned MCLK_HALF = CCD_MCLK_HALF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_master,
    output logic o_tick
);

    localparam int unsigned DIV_W = (MCLK_HALF > 1) ? $clog2(MCLK_HALF) : 1;
    localparam logic [DIV_W-1:0] DIV_TC  = DIV_W'(MCLK_HALF - 1);
    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

    logic [DIV_W-1:0] r_div;
    logic             r_master;
    logic             w_tc;

    assign w_tc     = (r_div == DIV_TC);
    // High during the cycle whose closing edge toggles Master from 0 to 1, so
    // downstream registers enabled by it change together with the Master rise.
    assign o_tick   = w_tc & ~r_master;
    assign o_master = r_master;

    // Half-period counter; Master toggles each time it wraps.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div    <= {DIV_W{1'b0}};
            r_master <= 1'b0;
        end else if (w_tc) begin
            r_div    <= {DIV_W{1'b0}};
            r_master <= ~r_master;
        end else begin
            r_div    <= r_div + DIV_ONE;
            r_master <= r_master;
        end
    end

endmodule

// File: rtl/ccd_interface.sv
// Linear CCD timing generator: Master clock, Icg frame gate and Sh shutter
// pulses. Icg/Sh are registered and only change on the Master rising edge.
module ccd_interface
    import ccd_pkg::*;
#(
    parameter int unsigned MCLK_HALF = CCD_MCLK_HALF,
    parameter int unsigned FRAME_LEN = CCD_FRAME_LEN,
    parameter int unsigned ICG_LOW   = CCD_ICG_LOW,
    parameter int unsigned SH_START  = CCD_SH_START,
    parameter int unsigned SH_WIDTH  = CCD_SH_WIDTH,
    parameter int unsigned SH_MIN    = CCD_SH_MIN
) (
    input  logic        clk_50m,
    input  logic        rst,
    input  logic [15:0] SH_Pulse,
    output logic        Master,
    output logic        Icg,
    output logic        Sh
);

    localparam int unsigned F_W = $clog2(FRAME_LEN);
    localparam logic [F_W-1:0] F_LAST  = F_W'(FRAME_LEN - 1);
    localparam logic [F_W-1:0] F_ZERO  = F_W'(0);
    localparam logic [F_W-1:0] F_ONE   = F_W'(1);
    localparam logic [F_W-1:0] F_ICG   = F_W'(ICG_LOW);
    localparam logic [F_W-1:0] F_SHS   = F_W'(SH_START);
    localparam logic [15:0]    P_MIN   = 16'(SH_MIN);
    localparam logic [15:0]    S_WID   = 16'(SH_WIDTH);
    localparam logic [31:0]    L_FRAME = 32'(FRAME_LEN);
    localparam logic [31:0]    L_WID   = 32'(SH_WIDTH);

    logic           w_tick;
    logic           w_master;

    logic [F_W-1:0] r_f;
    logic [15:0]    r_s;
    logic [15:0]    r_p;
    logic           r_icg;
    logic           r_sh;

    logic [F_W-1:0] w_f_next;
    logic [15:0]    w_p_next;
    logic [15:0]    w_s_next;
    logic           w_in_pulse;
    logic           w_fits;
    logic           w_icg_next;
    logic           w_sh_next;

    ccd_mclk_div #(
        .MCLK_HALF (MCLK_HALF)
    ) u_div (
        .i_clk    (clk_50m),
        .i_rst_n  (rst),
        .o_master (w_master),
        .o_tick   (w_tick)
    );

    assign Master = w_master;
    assign Icg    = r_icg;
    assign Sh     = r_sh;

    // Next frame position, Sh phase and gate levels for the coming tick.
    always_comb begin
        w_f_next   = F_ZERO;
        w_p_next   = r_p;
        w_s_next   = 16'd0;
        w_in_pulse = 1'b0;
        w_fits     = 1'b0;
        w_icg_next = 1'b1;
        w_sh_next  = 1'b0;

        if (r_f == F_LAST) begin
            w_f_next = F_ZERO;
        end else begin
            w_f_next = r_f + F_ONE;
        end

        // Sh period is sampled only at frame start so a frame is never torn.
        if (w_f_next == F_ZERO) begin
            w_p_next = clamp_period(SH_Pulse, P_MIN);
        end else begin
            w_p_next = r_p;
        end

        // Phase restarts at the transfer pulse and then wraps modulo the period.
        if (w_f_next <= F_SHS) begin
            w_s_next = 16'd0;
        end else if ((r_s + 16'd1) >= r_p) begin
            w_s_next = 16'd0;
        end else begin
            w_s_next = r_s + 16'd1;
        end

        w_in_pulse = (w_f_next >= F_SHS) && (w_s_next < S_WID);
        // Pulse start = f - s; it must end within the frame: start + W <= L.
        w_fits     = (32'(w_f_next) + L_WID) <= (L_FRAME + 32'(w_s_next));
        w_sh_next  = w_in_pulse & w_fits;
        w_icg_next = (w_f_next >= F_ICG);
    end

    // Frame/Sh state advances only on ticks so outputs align with Master rising.
    always_ff @(posedge clk_50m or negedge rst) begin
        if (!rst) begin
            r_f   <= F_LAST;
            r_s   <= 16'd0;
            r_p   <= P_MIN;
            r_icg <= 1'b1;
            r_sh  <= 1'b0;
        end else if (w_tick) begin
            r_f   <= w_f_next;
            r_s   <= w_s_next;
            r_p   <= w_p_next;
            r_icg <= w_icg_next;
            r_sh  <= w_sh_next;
        end else begin
            r_f   <= r_f;
            r_s   <= r_s;
            r_p   <= r_p;
            r_icg <= r_icg;
            r_sh  <= r_sh;
        end
    end

endmodule

// File: tb/tb_ccd_interface.sv
// Directed bench for ccd_interface with small timing parameters
// (MCLK_HALF=2, FRAME_LEN=40, ICG_LOW=5, SH_START=1, SH_WIDTH=2, SH_MIN=4).
module tb_ccd_interface;

    logic        clk_50m = 1'b0;
    logic        rst;
    logic [15:0] SH_Pulse;
    logic        Master;
    logic        Icg;
    logic        Sh;

    int          vectors     = 0;
    int          miscompares = 0;
    int          f_exp;
    logic        cur_icg;
    logic        cur_sh;

    always #10 clk_50m = ~clk_50m;

    ccd_interface #(
        .MCLK_HALF (2),
        .FRAME_LEN (40),
        .ICG_LOW   (5),
        .SH_START  (1),
        .SH_WIDTH  (2),
        .SH_MIN    (4)
    ) dut (
        .clk_50m  (clk_50m),
        .rst      (rst),
        .SH_Pulse (SH_Pulse),
        .Master   (Master),
        .Icg      (Icg),
        .Sh       (Sh)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s f=%0d: observed %b expected %b", tag, f_exp, obs, exp);
        end
    endtask

    // Expected Sh-high mask for one frame: cnt pulses, 2 wide, starting at start+k*per.
    function automatic logic [39:0] mk(input int start, input int per, input int cnt);
        logic [39:0] m;
        m = '0;
        for (int k = 0; k < cnt; k++) begin
            m[start + k*per]     = 1'b1;
            m[start + k*per + 1] = 1'b1;
        end
        return m;
    endfunction

    // One Master period (4 clks); gates hold until the closing rising edge.
    task automatic tick_step(input logic [39:0] m);
        int   fn;
        logic icg_n;
        logic sh_n;
        fn    = (f_exp == 39) ? 0 : f_exp + 1;
        icg_n = (fn >= 5);
        sh_n  = m[fn];
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk_50m);
            chk("master", Master, (i == 1 || i == 4));
            if (i < 4) begin
                chk("icg_hold", Icg, cur_icg);
                chk("sh_hold", Sh, cur_sh);
            end else begin
                chk("icg", Icg, icg_n);
                chk("sh", Sh, sh_n);
            end
        end
        f_exp   = fn;
        cur_icg = icg_n;
        cur_sh  = sh_n;
    endtask

    // Run to the end of the current frame, changing SH_Pulse after tick chg_at.
    task automatic run_frame(input logic [39:0] m, input int chg_at, input logic [15:0] nsh);
        for (int t = 0; t < 40; t++) begin
            tick_step(m);
            if (f_exp == chg_at) SH_Pulse = nsh;
            if (f_exp == 39) break;
        end
    endtask

    initial begin
        rst      = 1'b0;
        SH_Pulse = 16'd7;
        f_exp    = 39;
        cur_icg  = 1'b1;
        cur_sh   = 1'b0;

        // Reset held for 3 clocks.
        repeat (3) begin
            @(negedge clk_50m);
            chk("rst_master", Master, 1'b0);
            chk("rst_icg", Icg, 1'b1);
            chk("rst_sh", Sh, 1'b0);
        end
        rst = 1'b1;
        @(negedge clk_50m);
        chk("pre_master", Master, 1'b0);
        chk("pre_icg", Icg, 1'b1);
        @(negedge clk_50m);
        chk("tick0_master", Master, 1'b1);
        chk("tick0_icg", Icg, 1'b0);
        chk("tick0_sh", Sh, 1'b0);
        f_exp   = 0;
        cur_icg = 1'b0;
        cur_sh  = 1'b0;

        // P=7 frame; switch to 10 mid-frame, effective next frame only.
        run_frame(mk(1, 7, 6), 20, 16'd10);
        run_frame(mk(1, 10, 4), 30, 16'd0);
        // Clamped to P=4.
        run_frame(mk(1, 4, 10), 10, 16'd13);
        // P=13: start 40 does not exist.
        run_frame(mk(1, 13, 3), 10, 16'd38);
        // P=38: start 39 suppressed (39+2>40).
        run_frame(mk(1, 0, 1), 10, 16'hFFFF);
        // Huge period: transfer pulse only.
        run_frame(mk(1, 0, 1), 10, 16'd7);

        // P=7 again, advance to f=8 where Sh is high, then reset asynchronously.
        for (int t = 0; t < 9; t++) tick_step(mk(1, 7, 6));
        chk("f8_sh_high", Sh, 1'b1);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_master", Master, 1'b0);
        chk("arst_icg", Icg, 1'b1);
        chk("arst_sh", Sh, 1'b0);
        repeat (2) @(negedge clk_50m);
        chk("arst_hold_master", Master, 1'b0);
        chk("arst_hold_icg", Icg, 1'b1);
        rst     = 1'b1;
        f_exp   = 39;
        @(negedge clk_50m);
        chk("re_pre_master", Master, 1'b0);
        chk("re_pre_icg", Icg, 1'b1);
        @(negedge clk_50m);
        chk("re_tick0_master", Master, 1'b1);
        chk("re_tick0_icg", Icg, 1'b0);
        chk("re_tick0_sh", Sh, 1'b0);
        f_exp   = 0;
        cur_icg = 1'b0;
        cur_sh  = 1'b0;
        tick_step(mk(1, 7, 6));
        tick_step(mk(1, 7, 6));
        tick_step(mk(1, 7, 6));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ccd_interface.md
Name: ccd_interface

Overview:
Timing generator for a linear CCD sensor (TCD1304-class).
- From the 50 MHz system clock it produces the sensor master clock (Master), the integration clear gate (Icg) and the shift/electronic-shutter gate (Sh).
- It sits between the FPGA clock domain and the CCD driver pins.
- The integration period is selected at run time by SH_Pulse.

Parameters:
- MCLK_HALF, 12: system clocks per Master half-period (Master = clk_50m / (2*MCLK_HALF)).
- FRAME_LEN, 14776: Master cycles per readout frame (ICG period).
- ICG_LOW, 5: Master cycles Icg is held low at frame start.
- SH_START, 1: frame count at which the first Sh pulse of a frame rises.
- SH_WIDTH, 2: Sh pulse width in Master cycles.
- SH_MIN, 4: minimum Sh period in Master cycles; smaller SH_Pulse values are clamped.
- Legal parameter set: SH_START >= 1; SH_START+SH_WIDTH < ICG_LOW < FRAME_LEN; SH_MIN > SH_WIDTH.

Ports:
- clk_50m  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- SH_Pulse  in  16  Sh period in Master cycles (electronic shutter / integration time).
- Master  out  1  CCD master clock, 50% duty.
- Icg  out  1  integration clear gate; idle high.
- Sh  out  1  shift gate; active high.

Behaviour:
- Reset (rst=0, asynchronous): Master=0, Icg=1, Sh=0, divider=0, frame count f=FRAME_LEN-1, Sh sub-counter s=0, latched period P=SH_MIN.
- Divider:
  - The divider counts 0..MCLK_HALF-1. At terminal count it wraps and Master toggles.
  - "tick" = the clk edge at which Master goes 0->1.
  - First tick occurs MCLK_HALF clk edges after reset release.
- Frame counter, per tick:
  - f wraps FRAME_LEN-1 -> 0, otherwise increments.
  - The first tick after reset therefore gives f=0, i.e. frame start.
  - Icg and Sh are registered and change only on tick edges, aligned with the Master rising edge. There is no extra latency.
- Icg = 0 for f in [0, ICG_LOW-1], and 1 otherwise.
- Period latch:
  - When f becomes 0, P <= max(SH_Pulse, SH_MIN).
  - SH_Pulse changes mid-frame take effect at the next frame start only.
- Sh generation:
  - For f < SH_START: Sh=0 and s=0.
  - When f == SH_START: s=0 and the pulse starts.
  - For f > SH_START: s increments modulo P.
  - Sh=1 while s < SH_WIDTH, subject to the end-of-frame suppression below.
  - Result: pulses rise at f = SH_START + k*P, each SH_WIDTH Master cycles wide.
- End-of-frame suppression:
  - A pulse whose start f satisfies f + SH_WIDTH > FRAME_LEN is suppressed; Sh stays 0 for it.
  - No pulse ever straddles a frame boundary.
- The first pulse of each frame lies entirely inside the Icg-low window. This is the transfer pulse; Sh falls before Icg rises.
- SH_Pulse >= FRAME_LEN: only the transfer pulse occurs each frame.
- rst asserted mid-frame: outputs return immediately to reset values. After release, the sequence restarts with a fresh frame at the first tick.
- Arithmetic:
  - f is ceil(log2(FRAME_LEN)) bits.
  - s and P are 16 bits; the clamp compare is unsigned.

Decomposition:
- Shared package ccd_pkg holds the default timing constants: MCLK_HALF, FRAME_LEN, ICG_LOW, SH_START, SH_WIDTH, SH_MIN.
- One sub-module, ccd_mclk_div, holds the divider. It outputs Master and the one-cycle tick strobe.
- Frame and Sh logic stays in ccd_interface.

Test Plan:
(Benches use MCLK_HALF=2, FRAME_LEN=40, ICG_LOW=5, SH_START=1, SH_WIDTH=2, SH_MIN=4 unless stated.)
- Reset/clock: hold rst=0 for 3 clks, release. Expect Master=0, Icg=1, Sh=0 during reset. Master rises on the 2nd clk edge after release, then has period 4 clks and 50% duty.
- Frame start, SH_Pulse=7:
  - Icg low for ticks f=0..4.
  - Sh high at f=1,2, then at f=8,9, 15,16, 22,23, 29,30, 36,37.
  - Icg low repeats every 40 ticks.
- Clamp: SH_Pulse=0. Sh pulses at f=1,5,9,...,37, each 2 ticks wide (P=4).
- Frame-end suppression: SH_Pulse=13. Pulses start at f=1, 14, 27; the pulse at 40 does not exist. With SH_Pulse=38, only the f=1 pulse occurs (start 39 is suppressed, since 39+2>40).
- Mid-frame change: switch SH_Pulse 7->10 at f=20. The current frame keeps P=7; the next frame uses pulses at f=1, 11, 21, 31.
- Reset mid-operation: assert rst during Sh high at f=8. Sh=0, Icg=1, Master=0 immediately. After release, the first tick gives f=0 with Icg falling.
